// File: rtl/damc_pkg.sv
// Shared DAMC definitions: scan FSM encoding, address/port widths and table entry layout.
// The address and port widths are also used by drc_top.
package damc_pkg;

  localparam int ADDR_W = 16;
  localparam int PORT_W = 5;

  localparam logic [PORT_W-1:0] PORT_UNREACHABLE = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } damc_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PORT_W-1:0] port;
  } damc_entry_t;

endpackage

// File: rtl/damc_lookup_engine_if.sv
// DRC -> DAMC lookup bus. The request is a strobe with no backpressure.
// The response is a single-cycle strobe that carries the resolved port.
interface damc_lookup_if;
  import damc_pkg::*;

  logic              DRC_DAMC_lookupValid;
  logic [ADDR_W-1:0] DRC_DAMC_lookupDeviceAddr;
  logic              DRC_DAMC_lookupRspValid;
  logic [PORT_W-1:0] DRC_DAMC_lookupRspPort;

  modport master (
    output DRC_DAMC_lookupValid,
    output DRC_DAMC_lookupDeviceAddr,
    input  DRC_DAMC_lookupRspValid,
    input  DRC_DAMC_lookupRspPort
  );

  modport slave (
    input  DRC_DAMC_lookupValid,
    input  DRC_DAMC_lookupDeviceAddr,
    output DRC_DAMC_lookupRspValid,
    output DRC_DAMC_lookupRspPort
  );
endinterface

// File: rtl/damc_req_fifo.sv
// Synchronous FIFO with a power-of-2 depth. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; otherwise the push is ignored.
module damc_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         iClk,
  input  logic         iResetN,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic [W-1:0] popData,
  output logic         full,
  output logic         empty
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wrPtr;
  logic [PW-1:0]   rdPtr;
  logic [CNTW-1:0] count;
  logic            doPush;
  logic            doPop;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  // NOTE: storage has no reset; the count decides validity, and leaving the array unreset lets it map to plain RAM/flops without reset routing.
  always_ff @(posedge iClk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtr + PW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/damc_lookup_engine.sv
// DAMC lookup responder. It keeps an address-to-port table maintained by learn writes
// and serves queued DRC lookups one at a time with a sequential scan.
module damc_lookup_engine
  import damc_pkg::*;
#(
  parameter int ENTRIES   = 8,
  parameter int REQ_DEPTH = 4,
  parameter int CW        = 4
) (
  input  logic              iClk,
  input  logic              iResetN,
  damc_lookup_if.slave      lookupBus,
  input  logic              CFG_DAMC_learnValid,
  input  logic [ADDR_W-1:0] CFG_DAMC_learnAddr,
  input  logic [PORT_W-1:0] CFG_DAMC_learnPort,
  output logic              DAMC_learnDrop,
  output logic              DAMC_reqOverflow,
  output logic [CW-1:0]     DAMC_entryCount
);

  localparam int IW = $clog2(ENTRIES);
  localparam logic [IW-1:0] LAST_IDX = IW'(ENTRIES - 1);

  damc_entry_t       entries [ENTRIES];
  logic [ENTRIES-1:0] entryValid;

  damc_state_e       state;
  damc_state_e       stateNext;
  logic [IW-1:0]     idx;
  logic [ADDR_W-1:0] curAddr;
  logic [PORT_W-1:0] rspPort;

  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [ADDR_W-1:0] fifoData;

  logic              learnHit;
  logic [IW-1:0]     learnHitIdx;
  logic              freeFound;
  logic [IW-1:0]     freeIdx;
  logic              scanHit;
  logic              learnIsAdd;

  damc_req_fifo #(
    .DEPTH (REQ_DEPTH),
    .W     (ADDR_W)
  ) reqFifo (
    .iClk     (iClk),
    .iResetN  (iResetN),
    .push     (lookupBus.DRC_DAMC_lookupValid),
    .pushData (lookupBus.DRC_DAMC_lookupDeviceAddr),
    .pop      (fifoPop),
    .popData  (fifoData),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Parallel search for the learn address and the lowest free slot (descending loop, so the lowest index wins).
  // NOTE: combinational blocks assign every output a default first and use blocking assignments, so no latch is inferred.
  always_comb begin
    learnHit    = 1'b0;
    learnHitIdx = '0;
    freeFound   = 1'b0;
    freeIdx     = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entryValid[i] && (entries[i].addr == CFG_DAMC_learnAddr)) begin
        learnHit    = 1'b1;
        learnHitIdx = IW'(i);
      end
      if (!entryValid[i]) begin
        freeFound = 1'b1;
        freeIdx   = IW'(i);
      end
    end
  end

  assign learnIsAdd = CFG_DAMC_learnValid && (CFG_DAMC_learnPort != PORT_UNREACHABLE);

  always_ff @(posedge iClk) begin
    if (learnIsAdd) begin
      if (learnHit)       entries[learnHitIdx].port <= CFG_DAMC_learnPort;
      else if (freeFound) entries[freeIdx] <= '{addr: CFG_DAMC_learnAddr, port: CFG_DAMC_learnPort};
    end
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      entryValid      <= '0;
      DAMC_entryCount <= '0;
      DAMC_learnDrop  <= 1'b0;
    end else begin
      DAMC_learnDrop <= 1'b0;
      if (learnIsAdd && !learnHit) begin
        if (freeFound) begin
          entryValid[freeIdx] <= 1'b1;
          DAMC_entryCount     <= DAMC_entryCount + CW'(1);
        end else begin
          DAMC_learnDrop <= 1'b1;
        end
      end else if (CFG_DAMC_learnValid && !learnIsAdd && learnHit) begin
        entryValid[learnHitIdx] <= 1'b0;
        DAMC_entryCount         <= DAMC_entryCount - CW'(1);
      end
    end
  end

  assign scanHit = entryValid[idx] && (entries[idx].addr == curAddr);

  always_comb begin
    stateNext = state;
    fifoPop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          stateNext = SCAN;
        end
      end
      // A learn write stalls the compare so it is redone against the updated table.
      SCAN: begin
        if (!CFG_DAMC_learnValid && (scanHit || idx == LAST_IDX)) stateNext = RESP;
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) state <= IDLE;
    else          state <= stateNext;
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      curAddr <= '0;
      idx     <= '0;
      rspPort <= PORT_UNREACHABLE;
    end else begin
      if (fifoPop) begin
        curAddr <= fifoData;
        idx     <= '0;
      end else if (state == SCAN && !CFG_DAMC_learnValid) begin
        if (scanHit)              rspPort <= entries[idx].port;
        else if (idx == LAST_IDX) rspPort <= PORT_UNREACHABLE;
        else                      idx     <= idx + IW'(1);
      end
    end
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) DAMC_reqOverflow <= 1'b0;
    else if (lookupBus.DRC_DAMC_lookupValid && fifoFull && !fifoPop) DAMC_reqOverflow <= 1'b1;
  end

  assign lookupBus.DRC_DAMC_lookupRspValid = (state == RESP);
  assign lookupBus.DRC_DAMC_lookupRspPort  = rspPort;

endmodule
